ifu_prefetch: RTL

- Parametrised successor to the single-cycle IFU. It owns the PC, issues instruction-memory reads over a variable-latency request/response interface, and buffers fetched words in a QDEPTH-entry queue.
- Delivers {pc, instruction} to decode with a valid/ready handshake.
- Accepts redirects (PC+4, reg-jump, j-jump, beq) that flush the queue and squash any in-flight read.
- Sits between imem and the decode/ID stage of the pipelined core.

---
 rtl/ifu_pkg.sv | 17 +
 rtl/ifu_prefetch_if.sv | 38 +++
 rtl/ifu_fifo.sv | 48 ++++
 rtl/ifu_prefetch.sv | 109 ++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared constants and types for the prefetching instruction-fetch unit.
package ifu_pkg;

    localparam logic [31:0] CODE_SEG_PC = 32'h0000_3000;

    localparam logic [1:0] NPC_SEL_PC_ADD_4 = 2'b00;
    localparam logic [1:0] NPC_SEL_REG_JMP  = 2'b01;
    localparam logic [1:0] NPC_SEL_J_JMP    = 2'b10;
    localparam logic [1:0] NPC_SEL_BEQ_JMP  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/ifu_prefetch_if.sv
// Bus bundle between the prefetch unit, instruction memory, decode and the redirect source.
interface ifu_prefetch_if #(
    parameter int AW     = 32,
    parameter int QDEPTH = 4
);
    // imem: every cycle with imem_req=1 is an accepted request; imem_rvalid returns data in order.
    // decode: the head transfers on any cycle where inst_valid & inst_ready; inst/inst_pc are
    // stable while inst_valid=1 and inst_ready=0, and read as zero when inst_valid=0.
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_rvalid;
    logic [31:0]   imem_rdata;

    logic          inst_valid;
    logic          inst_ready;
    logic [31:0]   inst;
    logic [AW-1:0] inst_pc;

    logic          redir_valid;
    logic [1:0]    NPCSel;
    logic [AW-1:0] redir_pc;
    logic [AW-1:0] regPC;
    logic [25:0]   redir_imm;

    ifu_pkg::ifu_state_e         state;
    logic [$clog2(QDEPTH):0]     count;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc, state, count,
        input  imem_rvalid, imem_rdata, inst_ready, redir_valid, NPCSel, redir_pc, regPC, redir_imm
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, state, count,
        output imem_rvalid, imem_rdata, inst_ready, redir_valid, NPCSel, redir_pc, regPC, redir_imm
    );

endinterface

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with flush; the head word is presented combinationally from storage.
module ifu_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (push && !flush && !reset) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign dout  = mem[rd_ptr];
    assign valid = (count != '0);

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetcher: owns the PC, keeps one imem read in flight, queues fetched words
// for decode and retargets the fetch stream on redirects.
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = CODE_SEG_PC,
    parameter int            QDEPTH   = 4
) (
    input  logic           clk,
    input  logic           reset,
    ifu_prefetch_if.master bus
);
    localparam int CW = $clog2(QDEPTH) + 1;

    ifu_state_e    state, state_nx;
    logic [AW-1:0] fetch_pc, fetch_pc_nx;
    logic [AW-1:0] req_addr, req_addr_nx;
    logic [AW-1:0] p4, target;
    logic          issue, push, pop, fifo_valid;
    logic [CW-1:0] count;
    logic [AW+31:0] head;

    always_comb begin
        p4     = bus.redir_pc + AW'(4);
        target = p4;
        case (bus.NPCSel)
            NPC_SEL_PC_ADD_4: target = p4;
            NPC_SEL_REG_JMP:  target = {bus.regPC[AW-1:2], 2'b00};
            NPC_SEL_J_JMP:    target = {p4[AW-1:28], bus.redir_imm, 2'b00};
            NPC_SEL_BEQ_JMP:  target = p4 + {{(AW-18){bus.redir_imm[15]}}, bus.redir_imm[15:0], 2'b00};
            default:          target = p4;
        endcase
    end

    // Only IDLE can issue and nothing is outstanding there, so the space check reduces to count.
    always_comb begin
        state_nx    = state;
        fetch_pc_nx = fetch_pc;
        req_addr_nx = req_addr;
        issue       = 1'b0;
        push        = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.redir_valid && (count < CW'(QDEPTH))) begin
                    issue       = 1'b1;
                    req_addr_nx = fetch_pc;
                    fetch_pc_nx = fetch_pc + AW'(4);
                    state_nx    = WAIT;
                end
            end
            WAIT: begin
                if (bus.imem_rvalid) begin
                    push     = !bus.redir_valid;
                    state_nx = IDLE;
                end else if (bus.redir_valid) begin
                    state_nx = DROP;
                end
            end
            DROP: begin
                if (bus.imem_rvalid) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (bus.redir_valid) begin
            fetch_pc_nx = target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= '0;
        end else begin
            state    <= state_nx;
            fetch_pc <= fetch_pc_nx;
            req_addr <= req_addr_nx;
        end
    end

    assign pop = fifo_valid && bus.inst_ready;

    ifu_fifo #(
        .W     (AW + 32),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (bus.redir_valid),
        .din   ({req_addr, bus.imem_rdata}),
        .dout  (head),
        .valid (fifo_valid),
        .count (count)
    );

    assign bus.imem_req   = issue && !reset;
    assign bus.imem_addr  = fetch_pc;
    assign bus.inst_valid = fifo_valid;
    assign bus.inst       = fifo_valid ? head[31:0] : 32'd0;
    assign bus.inst_pc    = fifo_valid ? head[AW+31:32] : '0;
    assign bus.state      = state;
    assign bus.count      = count;

endmodule
